reg_pipe: RTL and testbench

Parametrised elastic register pipeline: a generalised successor to the single-bit synchronous-reset D flip-flop. It carries WIDTH-bit words through DEPTH registered stages. Flow control is valid/ready with bubble collapsing, plus a synchronous flush and an occupancy count. It sits between datapath blocks that need a fixed register delay but must tolerate downstream back-pressure without losing or duplicating words.

---
 rtl/reg_pipe_pkg.sv | 16 +
 rtl/reg_pipe_stage.sv | 71 +++++++
 rtl/reg_pipe.sv | 133 +++++++++++++
 tb/tb_reg_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared constants and helpers for the reg_pipe elastic
// register pipeline.
//   REG_PIPE_WIDTH_DEF  default data word width
//   REG_PIPE_DEPTH_DEF  default number of register stages
//   reg_pipe_cnt_w()    width of the occupancy counter for a given depth
package reg_pipe_pkg;

  localparam int REG_PIPE_WIDTH_DEF = 20;
  localparam int REG_PIPE_DEPTH_DEF = 4;

  // The counter has to represent 0..DEPTH inclusive.
  function automatic int reg_pipe_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one stage of the reg_pipe elastic pipeline.
// Holds a valid bit and a data word (plus a parity bit when the
// REG_PIPE_PARITY_EN macro is defined).
//   clk      rising-edge clock
//   rst      synchronous active-high reset: valid <= 0, data <= RST_VAL
//   i_flush  synchronous clear of the valid bit (data holds)
//   i_load   stage is allowed to take the word offered by its source
//   i_valid  source valid bit
//   i_data   source data word
//   i_par    source parity bit (REG_PIPE_PARITY_EN only)
//   o_par    stored parity bit (REG_PIPE_PARITY_EN only)
//   o_valid  stored valid bit
//   o_data   stored data word
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH   = REG_PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
`ifdef REG_PIPE_PARITY_EN
  input  logic             i_par,
  output logic             o_par,
`endif
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= RST_VAL;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= i_valid;
      end
      // Data only moves with a real word; bubbles and flushes leave it alone.
      if (!i_flush && i_load && i_valid) begin
        r_data <= i_data;
      end
    end
  end

`ifdef REG_PIPE_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= ^RST_VAL;
    end else if (!i_flush && i_load && i_valid) begin
      r_par <= i_par;
    end
  end

  assign o_par = r_par;
`endif

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: parametrised elastic register pipeline with valid/ready flow
// control, bubble collapsing, synchronous flush and an occupancy count.
// Optional feature macro: REG_PIPE_PARITY_EN (per-stage even parity and the
// out_perr output).
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      synchronous clear of all stage valid bits and the count
//   in_valid   upstream word present
//   in_data    upstream word
//   in_ready   pipeline accepts in_data this cycle (combinational)
//   out_valid  last stage holds a word
//   out_data   last-stage word
//   out_ready  downstream accepts out_data this cycle
//   count      number of valid stages (registered)
//   out_perr   parity error on the last stage (REG_PIPE_PARITY_EN only)
//
// Handshake: a word moves across an interface on a cycle where both valid
// and ready are high at the rising edge; valid never depends on ready, and
// ready may depend combinationally on the downstream ready.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH   = REG_PIPE_WIDTH_DEF,
  parameter int               DEPTH   = REG_PIPE_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  out_data,
  input  logic                              out_ready,
`ifdef REG_PIPE_PARITY_EN
  output logic                              out_perr,
`endif
  output logic [reg_pipe_cnt_w(DEPTH)-1:0]  count
);

  localparam int CW = reg_pipe_cnt_w(DEPTH);

  logic [DEPTH-1:0] w_valid;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic [DEPTH:0]   w_rdy;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [CW-1:0]    r_count;

`ifdef REG_PIPE_PARITY_EN
  logic [DEPTH-1:0] w_par;
`endif

  // Ready chain: a stage can load if it is empty or the stage ahead of it
  // is loading. This is what lets bubbles collapse behind a stalled tail.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_rdy[i] = !w_valid[i] | w_rdy[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             w_src_valid;
    logic [WIDTH-1:0] w_src_data;

    if (i == 0) begin : g_head
      assign w_src_valid = in_valid;
      assign w_src_data  = in_data;
    end else begin : g_body
      assign w_src_valid = w_valid[i-1];
      assign w_src_data  = w_data[i-1];
    end

`ifdef REG_PIPE_PARITY_EN
    logic w_src_par;

    // Parity is generated once at entry and then carried with the word.
    if (i == 0) begin : g_par_head
      assign w_src_par = ^in_data;
    end else begin : g_par_body
      assign w_src_par = w_par[i-1];
    end
`endif

    reg_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_load  (w_rdy[i]),
      .i_valid (w_src_valid),
      .i_data  (w_src_data),
`ifdef REG_PIPE_PARITY_EN
      .i_par   (w_src_par),
      .o_par   (w_par[i]),
`endif
      .o_valid (w_valid[i]),
      .o_data  (w_data[i])
    );
  end

  assign w_in_hs  = in_valid & w_rdy[0];
  assign w_out_hs = w_valid[DEPTH-1] & out_ready;

  // Occupancy follows the two handshakes; a simultaneous in and out leaves
  // it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_in_hs && !w_out_hs) begin
      r_count <= r_count + CW'(1);
    end else if (!w_in_hs && w_out_hs) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = w_valid[DEPTH-1];
  assign out_data  = w_data[DEPTH-1];
  assign count     = r_count;

`ifdef REG_PIPE_PARITY_EN
  assign out_perr = w_valid[DEPTH-1] & ((^w_data[DEPTH-1]) != w_par[DEPTH-1]);
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: self-checking bench for reg_pipe (WIDTH=20, DEPTH=4).
// The reference model keeps the words in flight as a list of
// (word, stage position) pairs and moves them one position per cycle unless
// they sit in the solid block of words parked against a stalled output.
module tb_reg_pipe;

  localparam int             W  = 20;
  localparam int             D  = 4;
  localparam int             CW = $clog2(D + 1);
  localparam logic [W-1:0]   RV = 20'h01234;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;
`ifdef REG_PIPE_PARITY_EN
  logic          out_perr;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected and observed output words.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  // Reference model state.
  logic [W-1:0] m_word[$];
  int           m_pos[$];
  logic [W-1:0] m_last;

  reg_pipe #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef REG_PIPE_PARITY_EN
    .out_perr  (out_perr),
`endif
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model helpers ----------------
  function automatic logic m_ov();
    return (m_word.size() > 0) && (m_pos[0] == D - 1);
  endfunction

  function automatic logic m_ir();
    return (m_word.size() < D) || out_ready;
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of inputs, records handshakes, advances the model.
  task automatic drive_cycle(input logic vin, input logic [W-1:0] din,
                             input logic ordy, input logic fl, input logic rs);
    logic in_hs;
    logic out_hs;
    int   k;
    in_valid  = vin;
    in_data   = din;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
    in_hs  = vin && m_ir();
    out_hs = m_ov() && ordy;
    if (!rs && !fl && out_valid && out_ready) got_q.push_back(out_data);
    if (!rs && !fl && out_hs) exp_q.push_back(m_word[0]);
    @(posedge clk);
    if (rs) begin
      m_word.delete();
      m_pos.delete();
      m_last = RV;
    end else if (fl) begin
      m_word.delete();
      m_pos.delete();
    end else begin
      if (out_hs) begin
        void'(m_word.pop_front());
        void'(m_pos.pop_front());
      end
      k = 0;
      if (!out_hs) begin
        while (k < m_pos.size() && m_pos[k] == D - 1 - k) k++;
      end
      for (int j = k; j < m_pos.size(); j++) begin
        m_pos[j] = m_pos[j] + 1;
        if (m_pos[j] == D - 1) m_last = m_word[j];
      end
      if (in_hs) begin
        m_word.push_back(din);
        m_pos.push_back(0);
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * D + 4 && m_word.size() > 0; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL reset_out_data got %h exp %h", out_data, RV); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_streaming();
    int base;
    base = got_q.size();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, W'(i + 1), 1'b1, 1'b0, 1'b0);
      if (i == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 20'h00001) begin
          errors++; $display("FAIL stream_latency got v=%b d=%h exp v=1 d=00001", out_valid, out_data);
        end
      end
      if (i >= 3) begin
        checks++; if (count !== CW'(4)) begin errors++; $display("FAIL stream_count got %0d exp 4", count); end
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready got %b exp 1", in_ready); end
    end
    drain();
    checks++;
    if (got_q.size() - base != 8) begin
      errors++; $display("FAIL stream_words got %0d exp 8", got_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[base+i] !== W'(i + 1)) begin
          errors++; $display("FAIL stream_order got %h exp %h", got_q[base+i], W'(i + 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w[4];
    for (int i = 0; i < 4; i++) begin
      w[i] = W'($urandom);
      drive_cycle(1'b1, w[i], 1'b0, 1'b0, 1'b0);
    end
    checks++; if (count !== CW'(4)) begin errors++; $display("FAIL bp_count got %0d exp 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== w[0]) begin
        errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=%h", out_valid, out_data, w[0]);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready got %b exp 0", in_ready); end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    #1;
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL bp_release_count got %0d exp 3", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    checks++; if (out_data !== w[1]) begin errors++; $display("FAIL bp_release_data got %h exp %h", out_data, w[1]); end
    drain();
  endtask

  task automatic test_bubble();
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = W'($urandom);
    b = W'($urandom);
    drive_cycle(1'b1, a, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, b, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready got %b exp 1", in_ready); end
    end
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL bubble_count got %0d exp 2", count); end
    checks++; if (out_data !== a) begin errors++; $display("FAIL bubble_head got %h exp %h", out_data, a); end
    // The second word must be parked directly behind the first.
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== b) begin
      errors++; $display("FAIL bubble_adjacent got v=%b d=%h exp v=1 d=%h", out_valid, out_data, b);
    end
    drain();
  endtask

  task automatic test_flush();
    int base;
    base = got_q.size();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, W'($urandom_range(0, 4095)), 1'b0, 1'b0, 1'b0);
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    drive_cycle(1'b1, 20'hABCDE, 1'b0, 1'b1, 1'b0);
    checks++; if (count !== '0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b exp 0", out_valid); end
    end
    drive_cycle(1'b1, 20'h13579, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= D - 1; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (out_valid !== m_ov()) begin errors++; $display("FAIL flush_relatency got %b exp %b", out_valid, m_ov()); end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 20'h13579) begin
      errors++; $display("FAIL flush_first_word got v=%b d=%h exp v=1 d=13579", out_valid, out_data);
    end
    drain();
    for (int i = base; i < got_q.size(); i++) begin
      checks++; if (got_q[i] === 20'hABCDE) begin errors++; $display("FAIL flush_dropped got %h exp none", got_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 40) == 0), 1'b0);
      checks++; if (count !== CW'(m_word.size())) begin errors++; $display("FAIL rand_count got %0d exp %0d", count, m_word.size()); end
      checks++; if (in_ready !== m_ir()) begin errors++; $display("FAIL rand_in_ready got %b exp %b", in_ready, m_ir()); end
      checks++; if (out_valid !== m_ov()) begin errors++; $display("FAIL rand_out_valid got %b exp %b", out_valid, m_ov()); end
      checks++; if (out_data !== m_last) begin errors++; $display("FAIL rand_out_data got %h exp %h", out_data, m_last); end
    end
    drain();
  endtask

`ifdef REG_PIPE_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] pw;
    pw = W'($urandom);
    drive_cycle(1'b1, pw, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < D; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL parity_clean got %b exp 0", out_perr); end
    force dut.g_stage[D-1].u_stage.r_data = pw ^ 20'h00001;
    #1;
    checks++; if (out_perr !== 1'b1) begin errors++; $display("FAIL parity_flip got %b exp 1", out_perr); end
    release dut.g_stage[D-1].u_stage.r_data;
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (out_perr !== 1'b0) begin errors++; $display("FAIL parity_idle got %b exp 0", out_perr); end
  endtask
`endif

  task automatic test_reset_mid();
    for (int i = 0; i < D; i++) drive_cycle(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
    checks++; if (count !== CW'(D)) begin errors++; $display("FAIL rstmid_full got %0d exp %0d", count, D); end
    drive_cycle(1'b1, W'($urandom), 1'b0, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== RV) begin errors++; $display("FAIL rstmid_out_data got %h exp %h", out_data, RV); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", in_ready); end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_scoreboard();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sb_size got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL sb_word[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_last    = RV;
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
`ifdef REG_PIPE_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_scoreboard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
